// File: rtl/tick_sequencer_pkg.sv
// Shared constants for tick_sequencer: state encodings and parameter defaults.
package tick_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam int unsigned TS_WIDTH_DEF    = 4;
  localparam int unsigned TS_PRESCALE_DEF = 100000000;

endpackage

// File: rtl/tick_sequencer_mod_counter.sv
// Modulo-N counter: counts 0..mod_q-1 on step, flags the wrap position combinationally.
module mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] mod_q,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count;

  // mod_q >= 1 whenever step is asserted, so count+1 never carries out.
  assign wrap  = (r_count == (mod_q - 1'b1));
  assign count = r_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (step) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Start/stop/hold sequencer driving a modulo counter with a one-cycle wrap tick.
// Optional per-step prescaler enabled by defining TICK_SEQ_PRESCALE_EN.
module tick_sequencer #(
  parameter int WIDTH    = tick_sequencer_pkg::TS_WIDTH_DEF,
  parameter int PRESCALE = tick_sequencer_pkg::TS_PRESCALE_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             err
);
  import tick_sequencer_pkg::*;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_mod_q;
  logic             r_tick;
  logic             r_err;
  logic             w_start_req;
  logic             w_mod_ok;
  logic             w_step;
  logic             w_clear;
  logic             w_wrap;
  logic             w_pre_done;

`ifdef TICK_SEQ_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_pre;

  assign w_pre_done = (r_pre == PW'(PRESCALE - 1));

  // Cleared in IDLE (covers RUN entry) and on stop; holds its value while paused.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pre <= '0;
    end else if (r_state == ST_IDLE || stop) begin
      r_pre <= '0;
    end else if (r_state == ST_RUN && !hold) begin
      r_pre <= w_pre_done ? '0 : r_pre + 1'b1;
    end
  end
`else
  assign w_pre_done = 1'b1;
`endif

  assign w_start_req = (r_state == ST_IDLE) && start && !stop;
  assign w_mod_ok    = (modulus != '0);
  assign w_step      = (r_state == ST_RUN) && !stop && !hold && w_pre_done;
  assign w_clear     = (r_state == ST_IDLE) || stop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_req && w_mod_ok) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop)      w_state_nxt = ST_IDLE;
        else if (hold) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop)       w_state_nxt = ST_IDLE;
        else if (!hold) w_state_nxt = ST_RUN;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_mod_q <= '0;
      r_tick  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_step && w_wrap;
      if (w_start_req) begin
        r_err <= !w_mod_ok;
        if (w_mod_ok) r_mod_q <= modulus;
      end
    end
  end

  mod_counter #(
    .WIDTH (WIDTH)
  ) u_mod_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .step  (w_step),
    .clear (w_clear),
    .mod_q (r_mod_q),
    .count (count),
    .wrap  (w_wrap)
  );

  assign tick = r_tick;
  assign busy = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign err  = r_err;

endmodule

// File: tb/tb_tick_sequencer.sv
// Randomized + directed bench for tick_sequencer against a behavioural reference model.
module tb_tick_sequencer;

`ifdef TICK_SEQ_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         start, stop, hold;
  logic [W-1:0] modulus;
  logic [W-1:0] count;
  logic         tick, busy, err;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit m_active, m_paused, m_err, m_tick;
  int m_cnt, m_mod, m_pre;
  int cyc, last_tick;

  tick_sequencer #(
    .WIDTH    (W),
    .PRESCALE (P)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .modulus (modulus),
    .count   (count),
    .tick    (tick),
    .busy    (busy),
    .err     (err)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_paused = 0; m_err = 0; m_tick = 0;
    m_cnt = 0; m_mod = 0; m_pre = 0;
  endtask

  task automatic model_edge();
    if (!m_active) begin
      m_tick = 0;
      if (start && !stop) begin
        if (modulus == 0) m_err = 1;
        else begin
          m_err = 0; m_mod = int'(modulus); m_cnt = 0;
          m_active = 1; m_paused = 0; m_pre = 0;
        end
      end
    end else if (stop) begin
      m_active = 0; m_paused = 0; m_cnt = 0; m_tick = 0; m_pre = 0;
    end else if (m_paused) begin
      m_tick = 0;
      if (!hold) m_paused = 0;
    end else if (hold) begin
      m_paused = 1; m_tick = 0;
    end else begin
      m_pre++;
      m_tick = 0;
      if (m_pre == P) begin
        m_pre  = 0;
        m_cnt  = (m_cnt + 1) % m_mod;
        m_tick = (m_cnt == 0);
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge CLK);
    model_edge();
    cyc++;
    @(negedge CLK);
    check_val("count", int'(count), m_cnt);
    check_val("tick",  int'(tick),  int'(m_tick));
    check_val("busy",  int'(busy),  int'(m_active));
    check_val("err",   int'(err),   int'(m_err));
  endtask

  task automatic run(input int n);
    repeat (n) tick_clk();
  endtask

  task automatic run_gaps(input int n, input int gap);
    last_tick = -1;
    repeat (n) begin
      tick_clk();
      if (tick) begin
        if (last_tick >= 0) check_val("tick_gap", cyc - last_tick, gap);
        last_tick = cyc;
      end
    end
  endtask

  task automatic do_start(input int m);
    modulus = W'(m); start = 1'b1;
    tick_clk();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
  endtask

  task automatic run_until_cnt(input int target);
    int guard = 0;
    while (m_cnt != target && guard < 200) begin
      tick_clk();
      guard++;
    end
    check_val("reach_cnt", int'(m_cnt == target), 1);
  endtask

  initial begin
    int nticks;
    RESET = 1'b1; start = 0; stop = 0; hold = 0; modulus = '0;
    cyc = 0;
    model_reset();
    #2;
    check_val("rst_count", int'(count), 0);
    check_val("rst_busy",  int'(busy),  0);
    check_val("rst_tick",  int'(tick),  0);
    check_val("rst_err",   int'(err),   0);
    @(negedge CLK);
    RESET = 1'b0;

    // modulus 6: ticks every 6 steps
    do_start(6);
    run_gaps(6 * P * 3 + 2, 6 * P);
    do_stop();

    // illegal modulus sets err, a legal start clears it
    do_start(0);
    check_val("err_set", int'(err), 1);
    check_val("err_busy", int'(busy), 0);
    do_start(12);
    check_val("err_clr", int'(err), 0);
    run_gaps(12 * P * 2 + 2, 12 * P);
    do_stop();

    // hold at count 3
    do_start(6);
    run_until_cnt(3);
    hold = 1'b1;
    run(4);
    check_val("hold_cnt", int'(count), 3);
    hold = 1'b0;
    run(3 * P + 2);
    do_stop();

    // start, stop and hold together in RUN
    do_start(6);
    run(4);
    start = 1; stop = 1; hold = 1;
    tick_clk();
    start = 0; stop = 0; hold = 0;
    check_val("sss_cnt",  int'(count), 0);
    check_val("sss_busy", int'(busy),  0);

    // asynchronous reset mid-run at count 4
    do_start(6);
    run_until_cnt(4);
    #2 RESET = 1'b1;
    #1;
    check_val("arst_cnt",  int'(count), 0);
    check_val("arst_busy", int'(busy),  0);
    model_reset();
    #1 RESET = 1'b0;
    nticks = 0;
    repeat (20) begin
      tick_clk();
      if (tick) nticks++;
    end
    check_val("arst_noticks", nticks, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 19) == 0);
      hold    = ($urandom_range(0, 4) == 0);
      modulus = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 7));
      tick_clk();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter and modulus width in bits.
REQ-002 The block SHALL have parameter PRESCALE, default 100000000: CLK cycles per count step when prescaling is compiled in.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single 100 MHz clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: level-sampled request to begin counting.
REQ-006 The block SHALL have port stop, input, 1 bit: request to abort counting and return to idle.
REQ-007 The block SHALL have port hold, input, 1 bit: freezes the count while high.
REQ-008 The block SHALL have port modulus, input, WIDTH bits: the divide ratio, captured on start.
REQ-009 The block SHALL have port count, output, WIDTH bits: the current count value, driven to the board LEDs.
REQ-010 The block SHALL have port tick, output, 1 bit: a one-CLK pulse on each wrap.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-012 The block SHALL have port err, output, 1 bit: sticky flag for an illegal modulus at start.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-014 In IDLE with start=1 and stop=0, if modulus≥1 the block SHALL capture modulus into mod_q, clear count to 0 and enter RUN on the next edge.
REQ-015 In IDLE with start=1 and stop=0, if modulus==0 the block SHALL stay in IDLE and set err.
REQ-016 In RUN, on each step, count SHALL become 0 if count==mod_q-1, and count+1 otherwise.
REQ-017 The wrap step SHALL assert tick for exactly one CLK, registered in the same edge as the count returns to 0.
REQ-018 Count arithmetic SHALL be WIDTH bits with no carry-out, and count SHALL never exceed mod_q-1.
REQ-019 mod_q=1 SHALL hold count at 0 and assert tick on every step.
REQ-020 RUN with hold=1 SHALL enter PAUSE, and PAUSE with hold=0 SHALL return to RUN.
REQ-021 In PAUSE, count SHALL be frozen and tick SHALL be 0.
REQ-022 stop=1 in RUN or PAUSE SHALL return the block to IDLE with count=0 and tick=0 on the next edge.
REQ-023 When stop and start are high in the same cycle, stop SHALL win.
REQ-024 When stop and hold are high in the same cycle, stop SHALL win.
REQ-025 start SHALL be ignored in RUN and PAUSE.
REQ-026 A modulus change in RUN SHALL have no effect until the next start.
REQ-027 A new start with modulus≥1 SHALL clear err.
REQ-028 In IDLE, count SHALL be 0 and tick SHALL be 0.

Reset
REQ-029 RESET=1 SHALL immediately, independent of CLK, force: state=IDLE, count=0, mod_q=0, tick=0, busy=0, err=0, prescaler=0.
REQ-030 Asserting RESET mid-RUN SHALL abandon the sequence, and no tick SHALL be emitted after release until a new start.

Configuration
REQ-031 Macro TICK_SEQ_PRESCALE_EN defined: a step SHALL occur once every PRESCALE CLKs while in RUN.
REQ-032 With TICK_SEQ_PRESCALE_EN defined, the prescaler SHALL clear on RUN entry and on stop.
REQ-033 With TICK_SEQ_PRESCALE_EN defined, the prescaler SHALL freeze in PAUSE.
REQ-034 With TICK_SEQ_PRESCALE_EN defined, the first step SHALL occur PRESCALE CLKs after RUN entry.
REQ-035 Macro not defined: a step SHALL occur every CLK in RUN, and PRESCALE SHALL be unused.

Structure
REQ-036 A shared package SHALL hold: the state encoding constants (IDLE=2'b00, RUN=2'b01, PAUSE=2'b10) and the default WIDTH and PRESCALE constants.
REQ-037 One sub-module, mod_counter, SHALL be instantiated, with inputs step, clear, mod_q and outputs count and wrap.
REQ-038 The FSM, the mod_q capture and the prescaler SHALL stay in tick_sequencer.

Verification (macro undefined unless stated)
REQ-039 The bench SHALL cover: modulus=6, start pulse → count runs 0..5,0, with tick high on each 5→0 edge, exactly every 6 CLKs.
REQ-040 The bench SHALL cover: modulus=0, start → state IDLE, err=1, busy=0; then modulus=12, start → err=0, ticks every 12 CLKs.
REQ-041 The bench SHALL cover: modulus=6, hold high at count=3 for 4 CLKs → count stays 3, tick=0; then release → 4,5,0 with tick at the wrap.
REQ-042 The bench SHALL cover: start, stop and hold all high in RUN → IDLE next edge, count=0, busy=0.
REQ-043 The bench SHALL cover: RESET pulse between edges at count=4 → count=0 and busy=0 immediately, with no tick after release.
REQ-044 The bench SHALL cover: macro defined, PRESCALE=4, modulus=3 → count steps every 4 CLKs, first tick 12 CLKs after RUN entry.
